// File: rtl/flash_pkg.sv
// Shared definitions for the NOR flash command sequencer: FSM states,
// command bytes, unlock addresses and the command-sequence lookup table.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_STROBE = 3'd4,
    R_EVAL   = 3'd5,
    ABORT_W  = 3'd6,
    FINISH   = 3'd7
  } state_t;

  localparam logic [15:0] CMD_AA = 16'h00AA;
  localparam logic [15:0] CMD_55 = 16'h0055;
  localparam logic [15:0] CMD_A0 = 16'h00A0;
  localparam logic [15:0] CMD_80 = 16'h0080;
  localparam logic [15:0] CMD_30 = 16'h0030;
  localparam logic [15:0] CMD_F0 = 16'h00F0;

  localparam logic [17:0] UNLOCK_ADDR1 = 18'h00555;
  localparam logic [17:0] UNLOCK_ADDR2 = 18'h002AA;
  localparam logic [17:0] RESET_ADDR   = 18'h00000;

  localparam logic [15:0] ERASED_WORD = 16'hFFFF;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } bus_word_t;

  // One bus write of the program (4 steps) or sector-erase (6 steps) sequence.
  function automatic bus_word_t cmd_entry(input logic        erase,
                                          input logic [2:0]  step,
                                          input logic [17:0] addr,
                                          input logic [15:0] data);
    bus_word_t w;
    w.addr = UNLOCK_ADDR1;
    w.data = CMD_AA;
    if (erase) begin
      case (step)
        3'd0:    begin w.addr = UNLOCK_ADDR1; w.data = CMD_AA; end
        3'd1:    begin w.addr = UNLOCK_ADDR2; w.data = CMD_55; end
        3'd2:    begin w.addr = UNLOCK_ADDR1; w.data = CMD_80; end
        3'd3:    begin w.addr = UNLOCK_ADDR1; w.data = CMD_AA; end
        3'd4:    begin w.addr = UNLOCK_ADDR2; w.data = CMD_55; end
        default: begin w.addr = addr;         w.data = CMD_30; end
      endcase
    end else begin
      case (step)
        3'd0:    begin w.addr = UNLOCK_ADDR1; w.data = CMD_AA; end
        3'd1:    begin w.addr = UNLOCK_ADDR2; w.data = CMD_55; end
        3'd2:    begin w.addr = UNLOCK_ADDR1; w.data = CMD_A0; end
        default: begin w.addr = addr;         w.data = data;   end
      endcase
    end
    return w;
  endfunction

  function automatic logic [2:0] last_step(input logic erase);
    return erase ? 3'd5 : 3'd3;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Strobe timer for one flash bus cycle: holds WR_n or RD_n low for the
// configured number of clocks and flags the final low cycle.
module flash_bus_cycle #(
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_read,
  output logic wr_strobe_n,
  output logic rd_strobe_n,
  output logic sample,
  output logic done
);

  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);
  localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);

  logic       active;
  logic       reading;
  logic [3:0] cnt;

  assign done   = active && (cnt == 4'd0);
  assign sample = done && reading;

  // Strobes are flops so they cannot glitch low between bus cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active      <= 1'b0;
      reading     <= 1'b0;
      cnt         <= 4'd0;
      wr_strobe_n <= 1'b1;
      rd_strobe_n <= 1'b1;
    end else if (start) begin
      active      <= 1'b1;
      reading     <= is_read;
      cnt         <= is_read ? RD_LAST : WE_LAST;
      wr_strobe_n <= is_read;
      rd_strobe_n <= !is_read;
    end else if (active) begin
      if (cnt == 4'd0) begin
        active      <= 1'b0;
        wr_strobe_n <= 1'b1;
        rd_strobe_n <= 1'b1;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Issues NOR flash word-program / sector-erase command sequences, polls the
// toggle bit for completion, verifies the result and aborts on poll timeout.
module flash_cmd_sequencer
  import flash_pkg::*;
#(
  parameter int          WE_CYCLES  = 2,
  parameter int          RD_CYCLES  = 3,
  parameter logic [19:0] POLL_LIMIT = 20'hFFFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_ERASE,
  input  logic [17:0] REQ_ADDR,
  input  logic [15:0] REQ_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [17:0] FLASH_ADDR,
  output logic [15:0] FLASH_DQ_OUT,
  output logic        FLASH_DQ_OE,
  input  logic [15:0] FLASH_DQ_IN,
  output logic        FLASH_WR_n,
  output logic        FLASH_RD_n
);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  step;
  logic [19:0] poll_cnt;
  logic        aborting;

  logic        erase_q;
  logic [17:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] sample_last;
  logic        prev_toggle;

  logic        accept;
  logic        bus_start;
  logic        bus_read;
  logic        bus_sample;
  logic        bus_done;
  logic        poll_done;
  logic        poll_timeout;
  logic        verify_bad;

  flash_bus_cycle #(
    .WE_CYCLES (WE_CYCLES),
    .RD_CYCLES (RD_CYCLES)
  ) u_bus (
    .clk         (CLK),
    .rst         (RESET),
    .start       (bus_start),
    .is_read     (bus_read),
    .wr_strobe_n (FLASH_WR_n),
    .rd_strobe_n (FLASH_RD_n),
    .sample      (bus_sample),
    .done        (bus_done)
  );

  assign accept       = (state == IDLE) && REQ_VALID && REQ_READY;
  // Toggle-bit rule: the device is finished once DQ6 stops toggling.
  assign poll_done    = (poll_cnt > 20'd1) && (sample_last[6] == prev_toggle);
  assign poll_timeout = (poll_cnt >= POLL_LIMIT);
  assign verify_bad   = sample_last != (erase_q ? ERASED_WORD : data_q);

  always_comb begin
    state_nx  = state;
    bus_start = 1'b0;
    bus_read  = 1'b0;
    case (state)
      IDLE:     if (accept) state_nx = W_SETUP;
      W_SETUP,
      ABORT_W: begin
        bus_start = 1'b1;
        state_nx  = W_STROBE;
      end
      W_STROBE: if (bus_done) state_nx = W_HOLD;
      W_HOLD: begin
        if (aborting) begin
          state_nx = FINISH;
        end else if (step == last_step(erase_q)) begin
          bus_start = 1'b1;
          bus_read  = 1'b1;
          state_nx  = R_STROBE;
        end else begin
          state_nx = W_SETUP;
        end
      end
      R_STROBE: if (bus_done) state_nx = R_EVAL;
      R_EVAL: begin
        if (poll_done) begin
          state_nx = FINISH;
        end else if (poll_timeout) begin
          state_nx = ABORT_W;
        end else begin
          bus_start = 1'b1;
          bus_read  = 1'b1;
          state_nx  = R_STROBE;
        end
      end
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      step         <= 3'd0;
      poll_cnt     <= 20'd0;
      aborting     <= 1'b0;
      FLASH_ADDR   <= 18'd0;
      FLASH_DQ_OUT <= 16'd0;
      FLASH_DQ_OE  <= 1'b0;
      BUSY         <= 1'b0;
      REQ_READY    <= 1'b1;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
    end else begin
      state     <= state_nx;
      BUSY      <= (state_nx != IDLE);
      REQ_READY <= (state_nx == IDLE);
      DONE      <= (state_nx == FINISH);
      ERROR     <= (state_nx == FINISH) && (aborting || verify_bad);

      if (bus_sample) poll_cnt <= poll_cnt + 20'd1;

      case (state)
        IDLE: begin
          if (accept) begin
            step     <= 3'd0;
            poll_cnt <= 20'd0;
            aborting <= 1'b0;
            {FLASH_ADDR, FLASH_DQ_OUT} <= cmd_entry(REQ_ERASE, 3'd0, REQ_ADDR, REQ_DATA);
            FLASH_DQ_OE <= 1'b1;
          end
        end
        W_HOLD: begin
          if (!aborting) begin
            if (step == last_step(erase_q)) begin
              FLASH_ADDR   <= addr_q;
              FLASH_DQ_OUT <= 16'd0;
              FLASH_DQ_OE  <= 1'b0;
            end else begin
              step <= step + 3'd1;
              {FLASH_ADDR, FLASH_DQ_OUT} <= cmd_entry(erase_q, step + 3'd1, addr_q, data_q);
            end
          end
        end
        R_EVAL: begin
          if (!poll_done && poll_timeout) begin
            aborting     <= 1'b1;
            FLASH_ADDR   <= RESET_ADDR;
            FLASH_DQ_OUT <= CMD_F0;
            FLASH_DQ_OE  <= 1'b1;
          end
        end
        default: ;
      endcase

      // Release the bus as the command completes.
      if (state_nx == FINISH) begin
        FLASH_ADDR   <= 18'd0;
        FLASH_DQ_OUT <= 16'd0;
        FLASH_DQ_OE  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      erase_q <= REQ_ERASE;
      addr_q  <= REQ_ADDR;
      data_q  <= REQ_DATA;
    end
    if (bus_sample) begin
      sample_last <= FLASH_DQ_IN;
      prev_toggle <= sample_last[6];
    end
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer with a toggle-bit flash model.
module tb_flash_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_ERASE;
  logic [17:0] REQ_ADDR;
  logic [15:0] REQ_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [17:0] FLASH_ADDR;
  logic [15:0] FLASH_DQ_OUT;
  logic        FLASH_DQ_OE;
  logic [15:0] FLASH_DQ_IN;
  logic        FLASH_WR_n;
  logic        FLASH_RD_n;

  always #5 CLK = ~CLK;

  flash_cmd_sequencer #(
    .WE_CYCLES  (2),
    .RD_CYCLES  (3),
    .POLL_LIMIT (20'd8)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_ERASE    (REQ_ERASE),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_DATA     (REQ_DATA),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERROR        (ERROR),
    .FLASH_ADDR   (FLASH_ADDR),
    .FLASH_DQ_OUT (FLASH_DQ_OUT),
    .FLASH_DQ_OE  (FLASH_DQ_OE),
    .FLASH_DQ_IN  (FLASH_DQ_IN),
    .FLASH_WR_n   (FLASH_WR_n),
    .FLASH_RD_n   (FLASH_RD_n)
  );

  int vectors = 0;
  int fails   = 0;

  logic [17:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int          wr_width_log[$];
  logic [17:0] rd_addr_log[$];
  int          rd_width_log[$];
  int wr_low = 0, rd_low = 0, rd_idx = 0, accepts = 0;
  int overlap = 0, wr_oe_bad = 0, rd_oe_bad = 0;
  logic prev_wr = 1'b1, prev_rd = 1'b1;

  int          toggles = 0;
  logic        toggle_forever = 1'b0;
  logic [15:0] final_val = 16'hFFFF;

  logic [17:0] prog_addr [4];
  logic [15:0] prog_data [4];
  logic [17:0] erase_addr[6];
  logic [15:0] erase_data[6];

  // Reads 1..toggles alternate DQ6, then the device returns final_val.
  function automatic logic [15:0] model_word(input int k);
    if (toggle_forever || k <= toggles) return k[0] ? 16'h0040 : 16'h0000;
    return final_val;
  endfunction

  always @(negedge CLK) begin
    if (RESET) begin
      wr_low  = 0;
      rd_low  = 0;
      prev_wr = 1'b1;
      prev_rd = 1'b1;
    end else begin
      if (!FLASH_WR_n && !FLASH_RD_n) overlap++;
      if (REQ_VALID && REQ_READY) begin
        accepts++;
        rd_idx = 0;
      end
      if (!FLASH_WR_n) begin
        wr_low++;
        if (!FLASH_DQ_OE) wr_oe_bad++;
      end else if (!prev_wr) begin
        wr_addr_log.push_back(FLASH_ADDR);
        wr_data_log.push_back(FLASH_DQ_OUT);
        wr_width_log.push_back(wr_low);
        wr_low = 0;
      end
      if (!FLASH_RD_n) begin
        if (prev_rd) begin
          rd_idx++;
          FLASH_DQ_IN = model_word(rd_idx);
        end
        rd_low++;
        if (FLASH_DQ_OE) rd_oe_bad++;
      end else if (!prev_rd) begin
        rd_addr_log.push_back(FLASH_ADDR);
        rd_width_log.push_back(rd_low);
        rd_low = 0;
      end
      prev_wr = FLASH_WR_n;
      prev_rd = FLASH_RD_n;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_width_log.delete();
    rd_addr_log.delete();
    rd_width_log.delete();
  endtask

  task automatic send(input logic erase, input logic [17:0] addr, input logic [15:0] data);
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_ERASE = erase;
    REQ_ADDR  = addr;
    REQ_DATA  = data;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (DONE !== 1'b1 && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    check("done_seen", {31'd0, DONE}, 32'd1);
  endtask

  int n;

  initial begin
    prog_addr  = '{18'h00555, 18'h002AA, 18'h00555, 18'h01234};
    prog_data  = '{16'h00AA, 16'h0055, 16'h00A0, 16'hBEEF};
    erase_addr = '{18'h00555, 18'h002AA, 18'h00555, 18'h00555, 18'h002AA, 18'h10000};
    erase_data = '{16'h00AA, 16'h0055, 16'h0080, 16'h00AA, 16'h0055, 16'h0030};
    FLASH_DQ_IN = 16'h0000;
    REQ_VALID = 1'b0;
    REQ_ERASE = 1'b0;
    REQ_ADDR  = 18'd0;
    REQ_DATA  = 16'd0;
    RESET     = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", {31'd0, REQ_READY}, 32'd1);
    check("rst_busy",  {31'd0, BUSY}, 32'd0);
    check("rst_done",  {31'd0, DONE}, 32'd0);
    check("rst_error", {31'd0, ERROR}, 32'd0);
    check("rst_wr_n",  {31'd0, FLASH_WR_n}, 32'd1);
    check("rst_rd_n",  {31'd0, FLASH_RD_n}, 32'd1);
    check("rst_oe",    {31'd0, FLASH_DQ_OE}, 32'd0);
    check("rst_addr",  {14'd0, FLASH_ADDR}, 32'd0);
    check("rst_dq",    {16'd0, FLASH_DQ_OUT}, 32'd0);
    RESET = 1'b0;

    // Program 0x01234 <- 0xBEEF, DQ6 toggles for 3 reads.
    clear_logs();
    toggles = 3; final_val = 16'hBEEF;
    send(1'b0, 18'h01234, 16'hBEEF);
    wait_done(n);
    check("prog_error",   {31'd0, ERROR}, 32'd0);
    check("prog_latency", n, 32'd32);
    check("prog_nwr",     wr_addr_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      check("prog_wr_addr",  {14'd0, wr_addr_log[i]}, {14'd0, prog_addr[i]});
      check("prog_wr_data",  {16'd0, wr_data_log[i]}, {16'd0, prog_data[i]});
      check("prog_wr_width", wr_width_log[i], 32'd2);
    end
    check("prog_nrd", rd_addr_log.size(), 32'd4);
    if (rd_addr_log.size() > 0) begin
      check("prog_rd_addr",  {14'd0, rd_addr_log[0]}, 32'h01234);
      check("prog_rd_width", rd_width_log[0], 32'd3);
    end
    @(posedge CLK); #1;
    check("prog_done_pulse", {31'd0, DONE}, 32'd0);
    check("prog_ready_after", {31'd0, REQ_READY}, 32'd1);

    // Sector erase 0x10000, device reads back 0xFFFF immediately.
    clear_logs();
    toggles = 0; final_val = 16'hFFFF;
    send(1'b1, 18'h10000, 16'h0000);
    wait_done(n);
    check("erase_error",   {31'd0, ERROR}, 32'd0);
    check("erase_latency", n, 32'd32);
    check("erase_nwr",     wr_addr_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < wr_addr_log.size(); i++) begin
      check("erase_wr_addr", {14'd0, wr_addr_log[i]}, {14'd0, erase_addr[i]});
      check("erase_wr_data", {16'd0, wr_data_log[i]}, {16'd0, erase_data[i]});
    end
    check("erase_nrd", rd_addr_log.size(), 32'd2);

    // Program whose final read disagrees with the data word.
    clear_logs();
    toggles = 3; final_val = 16'hBEEE;
    send(1'b0, 18'h01234, 16'hBEEF);
    wait_done(n);
    check("verify_error", {31'd0, ERROR}, 32'd1);
    check("verify_nrd",   rd_addr_log.size(), 32'd4);
    @(posedge CLK); #1;
    check("verify_error_clear", {31'd0, ERROR}, 32'd0);

    // Poll timeout with POLL_LIMIT=8 and DQ6 toggling forever.
    clear_logs();
    toggle_forever = 1'b1;
    send(1'b0, 18'h01234, 16'hBEEF);
    wait_done(n);
    toggle_forever = 1'b0;
    check("tmo_error",   {31'd0, ERROR}, 32'd1);
    check("tmo_latency", n, 32'd52);
    check("tmo_nrd",     rd_addr_log.size(), 32'd8);
    check("tmo_nwr",     wr_addr_log.size(), 32'd5);
    if (wr_addr_log.size() == 5) begin
      check("tmo_rst_addr", {14'd0, wr_addr_log[4]}, 32'h0);
      check("tmo_rst_data", {16'd0, wr_data_log[4]}, 32'h00F0);
    end

    // Reset asserted during the third write strobe.
    clear_logs();
    toggles = 0; final_val = 16'hFFFF;
    send(1'b0, 18'h01234, 16'hBEEF);
    n = 0;
    while (!(wr_addr_log.size() == 2 && FLASH_WR_n == 1'b0) && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check("mid_reach_strobe3", {31'd0, FLASH_WR_n}, 32'd0);
    #2 RESET = 1'b1;
    #1;
    check("mid_wr_n", {31'd0, FLASH_WR_n}, 32'd1);
    check("mid_rd_n", {31'd0, FLASH_RD_n}, 32'd1);
    check("mid_busy", {31'd0, BUSY}, 32'd0);
    check("mid_oe",   {31'd0, FLASH_DQ_OE}, 32'd0);
    check("mid_addr", {14'd0, FLASH_ADDR}, 32'd0);
    check("mid_dq",   {16'd0, FLASH_DQ_OUT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    check("mid_ready", {31'd0, REQ_READY}, 32'd1);
    repeat (40) @(posedge CLK);
    #1;
    check("mid_no_more_wr", wr_addr_log.size(), 32'd2);
    check("mid_no_rd",      rd_addr_log.size(), 32'd0);
    check("mid_idle_busy",  {31'd0, BUSY}, 32'd0);

    // REQ_VALID held high across a busy command.
    clear_logs();
    accepts = 0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_ERASE = 1'b1;
    REQ_ADDR  = 18'h10000;
    REQ_DATA  = 16'h0000;
    @(posedge CLK); #1;
    wait_done(n);
    check("hold_accepts_busy", accepts, 32'd1);
    check("hold_ready_busy",   {31'd0, REQ_READY}, 32'd0);
    @(posedge CLK); #1;
    check("hold_ready_idle", {31'd0, REQ_READY}, 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("hold_accepts_2", accepts, 32'd2);
    check("hold_busy_2",    {31'd0, BUSY}, 32'd1);
    wait_done(n);
    check("hold_error_2", {31'd0, ERROR}, 32'd0);

    @(posedge CLK); #1;
    check("never_overlap", overlap, 32'd0);
    check("wr_oe_driven",  wr_oe_bad, 32'd0);
    check("rd_oe_off",     rd_oe_bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
